// File: rtl/vga_plot_sink.sv
// Pixel-plot sink: small plot FIFO in front of a single-port 160x120x3 frame memory,
// with a priority readback port that forwards still-queued plots.
module vga_plot_sink #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        rd_en,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic        rd_valid,
  output logic [2:0]  rd_colour,
  input  logic        clear,
  output logic        clear_done,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] plot_count,
  output logic [7:0]  drop_count
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned NumPix   = 160 * 120;
  localparam logic [14:0] LastAddr = 15'(NumPix - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  // ---------------------------------------------------------------------------
  // Address generation: y*160 + x = (y << 7) + (y << 5) + x
  // ---------------------------------------------------------------------------
  logic [14:0] plot_addr;
  logic [14:0] rd_addr;
  logic        plot_in_range;

  assign plot_addr     = {vga_y, 8'b0} >> 1;
  assign rd_addr       = ({rd_y, 8'b0} >> 1) + ({8'b0, rd_y} << 5) + {7'b0, rd_x};
  assign plot_in_range = (vga_x < 8'd160) && (vga_y < 7'd120);

  logic [14:0] plot_addr_full;
  assign plot_addr_full = plot_addr + ({8'b0, vga_y} << 5) + {7'b0, vga_x};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  logic [14:0]   clr_addr_q, clr_addr_d;
  logic          clear_done_q, clear_done_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   plot_count_q, plot_count_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          rd_valid_q;
  logic          fwd_hit_q;
  logic [2:0]    fwd_colour_q;
  logic [2:0]    mem_rdata_q;

  logic [14:0] fifo_addr [DEPTH];
  logic [2:0]  fifo_colour [DEPTH];
  logic [2:0]  mem [NumPix];

  // ---------------------------------------------------------------------------
  // Arbitration: read beats clear beats drain
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic clr_we;
  logic clr_last;

  assign fifo_full  = (count_q == (PW + 1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign clr_we     = !rd_en && (state_q == StClear);
  assign clr_last   = clr_we && (clr_addr_q == LastAddr);
  assign pop        = !rd_en && (state_q == StIdle) && !fifo_empty;
  assign push       = vga_plot && plot_in_range && (!fifo_full || pop);

  logic        mem_we;
  logic [14:0] mem_waddr;
  logic [2:0]  mem_wdata;

  // Writes are suppressed during reset so pending plots are truly lost.
  assign mem_we    = rst_n && (clr_we || pop);
  assign mem_waddr = clr_we ? clr_addr_q : fifo_addr[rd_ptr_q];
  assign mem_wdata = clr_we ? 3'b000 : fifo_colour[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Forwarding: scan oldest to youngest so the youngest match wins
  // ---------------------------------------------------------------------------
  logic          fwd_hit;
  logic [2:0]    fwd_colour;
  logic [PW-1:0] fwd_idx;

  always_comb begin
    fwd_hit    = 1'b0;
    fwd_colour = 3'b000;
    fwd_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (((PW + 1)'(i) < count_q) && (fifo_addr[fwd_idx] == rd_addr)) begin
        fwd_hit    = 1'b1;
        fwd_colour = fifo_colour[fwd_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clear_done_d = 1'b0;
    overflow_d   = overflow_q;
    plot_count_d = plot_count_q;
    drop_count_d = drop_count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        if (clr_we) begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
        if (clr_last) begin
          state_d      = StIdle;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (plot_count_q != 16'hFFFF) begin
        plot_count_d = plot_count_q + 16'd1;
      end
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (vga_plot && plot_in_range && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
    if (vga_plot && !plot_in_range && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clr_addr_q   <= '0;
      clear_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      plot_count_q <= '0;
      drop_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      fwd_hit_q    <= 1'b0;
      fwd_colour_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clear_done_q <= clear_done_d;
      overflow_q   <= overflow_d;
      plot_count_q <= plot_count_d;
      drop_count_q <= drop_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_valid_q   <= rd_en;
      if (rd_en) begin
        fwd_hit_q    <= fwd_hit;
        fwd_colour_q <= fwd_colour;
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q]   <= plot_addr_full;
      fifo_colour[wr_ptr_q] <= vga_colour;
    end
  end

  // Single-port frame memory: a write and a read never coincide by construction.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end else if (rd_en) begin
      mem_rdata_q <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_valid   = rd_valid_q;
  assign rd_colour  = rd_valid_q ? (fwd_hit_q ? fwd_colour_q : mem_rdata_q) : 3'b000;
  assign clear_done = clear_done_q;
  assign busy       = (state_q == StClear) || !fifo_empty;
  assign overflow   = overflow_q;
  assign plot_count = plot_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed, table-driven bench for vga_plot_sink with hand-computed expectations.
module tb_vga_plot_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        rd_en;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_valid;
  logic [2:0]  rd_colour;
  logic        clear;
  logic        clear_done;
  logic        busy;
  logic        overflow;
  logic [15:0] plot_count;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  vga_plot_sink #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .rd_colour  (rd_colour),
    .clear      (clear),
    .clear_done (clear_done),
    .busy       (busy),
    .overflow   (overflow),
    .plot_count (plot_count),
    .drop_count (drop_count)
  );

  typedef struct {
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic        rd;
    logic [7:0]  rx;
    logic [6:0]  ry;
    logic        exp_valid;
    logic [2:0]  exp_colour;
    logic        exp_busy;
    logic        exp_ovf;
    logic [15:0] exp_pc;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   k;

  function automatic vec_t mk(input int plot, input int x, input int y, input int c,
                              input int rd, input int rx, input int ry,
                              input int ev, input int ec, input int eb, input int eo,
                              input int epc, input int edrop);
    vec_t v;
    v.plot = 1'(plot); v.x = 8'(x); v.y = 7'(y); v.c = 3'(c);
    v.rd = 1'(rd); v.rx = 8'(rx); v.ry = 7'(ry);
    v.exp_valid = 1'(ev); v.exp_colour = 3'(ec); v.exp_busy = 1'(eb); v.exp_ovf = 1'(eo);
    v.exp_pc = 16'(epc); v.exp_drop = 8'(edrop);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_plot = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0;
    rd_en = 1'b0; rd_x = '0; rd_y = '0; clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rd_valid"}, int'(rd_valid), 0);
    check({tag, " rd_colour"}, int'(rd_colour), 0);
    check({tag, " clear_done"}, int'(clear_done), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " overflow"}, int'(overflow), 0);
    check({tag, " plot_count"}, int'(plot_count), 0);
    check({tag, " drop_count"}, int'(drop_count), 0);
  endtask

  task automatic do_read(input int x, input int y, input int exp, input string tag);
    rd_en = 1'b1; rd_x = 8'(x); rd_y = 7'(y);
    step();
    rd_en = 1'b0;
    check({tag, " rd_valid"}, int'(rd_valid), 1);
    check({tag, " rd_colour"}, int'(rd_colour), exp);
  endtask

  task automatic plot_one(input int x, input int y, input int c);
    vga_plot = 1'b1; vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c);
    step();
    vga_plot = 1'b0;
  endtask

  task automatic wait_clear_done(output int cycles);
    cycles = 0;
    while (!clear_done && cycles < 20000) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    // Reads of the cleared image
    vecs.push_back(mk(0, 0, 0, 0,   1, 0, 0,     1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 159, 119, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 80, 60,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 0, 0, 0, 0));
    // Single plot: queued, then committed one edge later
    vecs.push_back(mk(1, 10, 20, 5, 0, 0, 0,     0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 10, 20,   1, 5, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 0, 0, 1, 0));
    // Reads stall the drain; same-cycle plots not forwarded; youngest match wins
    vecs.push_back(mk(1, 5, 5, 1,   1, 0, 0,     1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 5, 5, 6,   1, 0, 0,     1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 7, 7, 2,   1, 0, 0,     1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 5, 5,     1, 6, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 7, 7,     1, 2, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 1, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 5, 5,     1, 6, 0, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 7, 7,     1, 2, 0, 0, 4, 0));
    // Overflow: 6 plots with reads held, only the first 4 survive
    vecs.push_back(mk(1, 20, 1, 1,  1, 0, 0,     1, 0, 1, 0, 4, 0));
    vecs.push_back(mk(1, 21, 1, 2,  1, 0, 0,     1, 0, 1, 0, 4, 0));
    vecs.push_back(mk(1, 22, 1, 3,  1, 0, 0,     1, 0, 1, 0, 4, 0));
    vecs.push_back(mk(1, 23, 1, 4,  1, 0, 0,     1, 0, 1, 0, 4, 0));
    vecs.push_back(mk(1, 24, 1, 5,  1, 0, 0,     1, 0, 1, 1, 4, 0));
    vecs.push_back(mk(1, 25, 1, 6,  1, 0, 0,     1, 0, 1, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 23, 1,    1, 4, 1, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 1, 1, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 1, 1, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 1, 1, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 0, 1, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 24, 1,    1, 0, 0, 1, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 25, 1,    1, 0, 0, 1, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 22, 1,    1, 3, 0, 1, 8, 0));
    // Out-of-range plots are counted and never queued
    vecs.push_back(mk(1, 160, 0, 7, 0, 0, 0,     0, 0, 0, 1, 8, 1));
    vecs.push_back(mk(1, 0, 120, 7, 0, 0, 0,     0, 0, 0, 1, 8, 2));
    vecs.push_back(mk(1, 255, 127, 7, 0, 0, 0,   0, 0, 0, 1, 8, 3));
    vecs.push_back(mk(0, 0, 0, 0,   1, 0, 1,     1, 0, 0, 1, 8, 3));
    // Full FIFO accepts a push when a pop happens in the same cycle
    vecs.push_back(mk(1, 30, 2, 1,  1, 0, 0,     1, 0, 1, 1, 8, 3));
    vecs.push_back(mk(1, 31, 2, 2,  1, 0, 0,     1, 0, 1, 1, 8, 3));
    vecs.push_back(mk(1, 32, 2, 3,  1, 0, 0,     1, 0, 1, 1, 8, 3));
    vecs.push_back(mk(1, 33, 2, 4,  1, 0, 0,     1, 0, 1, 1, 8, 3));
    vecs.push_back(mk(1, 34, 2, 5,  0, 0, 0,     0, 0, 1, 1, 9, 3));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 1, 1, 10, 3));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 1, 1, 11, 3));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 1, 1, 12, 3));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,     0, 0, 0, 1, 13, 3));
    vecs.push_back(mk(0, 0, 0, 0,   1, 34, 2,    1, 5, 0, 1, 13, 3));
    vecs.push_back(mk(0, 0, 0, 0,   1, 30, 2,    1, 1, 0, 1, 13, 3));

    // Reset
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Full clear: 19200 cycles from the sampling edge to clear_done
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear busy", int'(busy), 1);
    wait_clear_done(k);
    check("clear duration", k, 19200);
    check("clear plot_count", int'(plot_count), 0);
    step();
    check("clear_done pulse width", int'(clear_done), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vga_plot = vecs[i].plot; vga_x = vecs[i].x; vga_y = vecs[i].y; vga_colour = vecs[i].c;
      rd_en = vecs[i].rd; rd_x = vecs[i].rx; rd_y = vecs[i].ry;
      step();
      check($sformatf("v%0d rd_valid", i), int'(rd_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d rd_colour", i), int'(rd_colour), int'(vecs[i].exp_colour));
      end
      check($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].exp_busy));
      check($sformatf("v%0d overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
      check($sformatf("v%0d plot_count", i), int'(plot_count), int'(vecs[i].exp_pc));
      check($sformatf("v%0d drop_count", i), int'(drop_count), int'(vecs[i].exp_drop));
    end
    idle_inputs();

    // drop_count saturation
    vga_plot = 1'b1; vga_x = 8'd200; vga_y = 7'd0;
    repeat (300) step();
    vga_plot = 1'b0;
    check("drop saturate", int'(drop_count), 255);
    check("drop busy", int'(busy), 0);
    check("drop plot_count", int'(plot_count), 13);

    // Reset mid-clear with a queued plot: everything back to reset values
    clear = 1'b1;
    step();
    clear = 1'b0;
    plot_one(1, 1, 7);
    repeat (97) step();
    check("midclear busy", int'(busy), 1);
    rst_n = 1'b0;
    step();
    check_reset_outputs("midclear reset");
    rst_n = 1'b1;
    repeat (3) step();
    check("post-reset busy", int'(busy), 0);
    check("post-reset plot_count", int'(plot_count), 0);

    // Same again without reset: plot lands over the cleared image
    clear = 1'b1;
    step();
    clear = 1'b0;
    plot_one(1, 1, 7);
    wait_clear_done(k);
    check("clear2 done seen", int'(clear_done), 1);
    check("clear2 plot_count held", int'(plot_count), 0);
    repeat (3) step();
    check("clear2 plot_count", int'(plot_count), 1);
    check("clear2 busy", int'(busy), 0);
    do_read(1, 1, 7, "clear2 (1,1)");
    do_read(10, 20, 0, "clear2 (10,20)");
    do_read(5, 5, 0, "clear2 (5,5)");
    step();
    check("final rd_valid", int'(rd_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
